// File: rtl/apu_wave_channel.sv
`default_nettype none
// ============================================================================
// Module   : apu_wave_channel
// Purpose  : Timer-driven triangle/sawtooth voice gated by linear and length
//            counters, with optional ultrasonic-period mute.
// Revision : 1.0 - initial release
// ============================================================================
module apu_wave_channel #(
  parameter logic [4:0] BASE_ADDR  = 5'h08,
  parameter int         TIMER_W    = 11,
  parameter int         SEQ_W      = 5,
  parameter int         OUT_W      = 4,
  parameter int         LIN_W      = 7,
  parameter bit         ULTRA_MUTE = 1'b1
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             cpu_clock,
  input  logic             apu_cs,
  input  logic [4:0]       ioreg_addr,
  input  logic [7:0]       ioreg_datain,
  input  logic             ioreg_wr,
  input  logic             en_channel,
  input  logic             frame_l,
  input  logic             frame_e,
  output logic             lcounter_status,
  output logic [OUT_W-1:0] wave_out
);

  localparam logic [4:0] ADDR_R0 = BASE_ADDR;
  localparam logic [4:0] ADDR_R1 = BASE_ADDR + 5'd1;
  localparam logic [4:0] ADDR_R2 = BASE_ADDR + 5'd2;
  localparam logic [4:0] ADDR_R3 = BASE_ADDR + 5'd3;

  logic               ctrl_q, ctrl_d;
  logic [LIN_W-1:0]   lin_rld_q, lin_rld_d;
  logic               mode_q, mode_d;
  logic [7:0]         r2_q, r2_d;
  logic [7:0]         r3_q, r3_d;
  logic               load_pend_q, load_pend_d;
  logic [TIMER_W-1:0] period_q, period_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         len_q, len_d;
  logic [LIN_W-1:0]   lin_q, lin_d;
  logic               rflag_q, rflag_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;

  logic               wr_stb;
  logic [TIMER_W-1:0] period_new;
  logic               step;
  logic               seq_run;
  logic               rflag_eff;
  logic [OUT_W-1:0]   tri_val;
  logic [OUT_W-1:0]   saw_val;

  function automatic logic [7:0] len_lut(input logic [4:0] idx);
    case (idx)
      5'd0:  len_lut = 8'd10;   5'd1:  len_lut = 8'd254;
      5'd2:  len_lut = 8'd20;   5'd3:  len_lut = 8'd2;
      5'd4:  len_lut = 8'd40;   5'd5:  len_lut = 8'd4;
      5'd6:  len_lut = 8'd80;   5'd7:  len_lut = 8'd6;
      5'd8:  len_lut = 8'd160;  5'd9:  len_lut = 8'd8;
      5'd10: len_lut = 8'd60;   5'd11: len_lut = 8'd10;
      5'd12: len_lut = 8'd14;   5'd13: len_lut = 8'd12;
      5'd14: len_lut = 8'd26;   5'd15: len_lut = 8'd14;
      5'd16: len_lut = 8'd12;   5'd17: len_lut = 8'd16;
      5'd18: len_lut = 8'd24;   5'd19: len_lut = 8'd18;
      5'd20: len_lut = 8'd48;   5'd21: len_lut = 8'd20;
      5'd22: len_lut = 8'd96;   5'd23: len_lut = 8'd22;
      5'd24: len_lut = 8'd192;  5'd25: len_lut = 8'd24;
      5'd26: len_lut = 8'd72;   5'd27: len_lut = 8'd26;
      5'd28: len_lut = 8'd16;   5'd29: len_lut = 8'd28;
      5'd30: len_lut = 8'd32;   default: len_lut = 8'd30;
    endcase
  endfunction

  generate
    if (TIMER_W > 8) begin : g_period_hi
      assign period_new = {r3_q[TIMER_W-9:0], r2_q};
    end else begin : g_period_lo
      assign period_new = r2_q;
    end
  endgenerate

  assign wr_stb    = apu_cs & ioreg_wr & cpu_clock;
  assign step      = cpu_clock & ~load_pend_q & (timer_q == '0);
  assign seq_run   = (len_q != 8'd0) & (lin_q != '0) &
                     ~(ULTRA_MUTE & (period_q < TIMER_W'(2)));
  // A pending R3 load counts as a set reload flag for a coincident linear tick.
  assign rflag_eff = rflag_q | load_pend_q;

  always_comb begin
    ctrl_d      = ctrl_q;
    lin_rld_d   = lin_rld_q;
    mode_d      = mode_q;
    r2_d        = r2_q;
    r3_d        = r3_q;
    load_pend_d = 1'b0;
    period_d    = period_q;
    timer_d     = timer_q;
    len_d       = len_q;
    lin_d       = lin_q;
    rflag_d     = rflag_eff;
    seq_d       = seq_q;

    if (wr_stb) begin
      if (ioreg_addr == ADDR_R0) begin
        ctrl_d    = ioreg_datain[7];
        lin_rld_d = ioreg_datain[LIN_W-1:0];
      end
      if (ioreg_addr == ADDR_R1) mode_d = ioreg_datain[0];
      if (ioreg_addr == ADDR_R2) r2_d = ioreg_datain;
      if (ioreg_addr == ADDR_R3) begin
        r3_d        = ioreg_datain;
        load_pend_d = 1'b1;
      end
    end

    if (load_pend_q) begin
      period_d = period_new;
      timer_d  = period_new;
    end else if (cpu_clock) begin
      timer_d = (timer_q == '0) ? period_q : timer_q - TIMER_W'(1);
    end

    if (!en_channel) begin
      len_d = 8'd0;
    end else if (load_pend_q) begin
      len_d = len_lut(r3_q[7:3]);
    end else if (frame_l && (len_q != 8'd0) && !ctrl_q) begin
      len_d = len_q - 8'd1;
    end

    if (frame_e) begin
      if (rflag_eff) begin
        lin_d = lin_rld_q;
      end else if (lin_q != '0) begin
        lin_d = lin_q - LIN_W'(1);
      end
      if (!ctrl_q) rflag_d = 1'b0;
    end

    if (step && seq_run) seq_d = seq_q + SEQ_W'(1);
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      ctrl_q      <= 1'b0;
      lin_rld_q   <= '0;
      mode_q      <= 1'b0;
      r2_q        <= 8'd0;
      r3_q        <= 8'd0;
      load_pend_q <= 1'b0;
      period_q    <= '0;
      timer_q     <= '0;
      len_q       <= 8'd0;
      lin_q       <= '0;
      rflag_q     <= 1'b0;
      seq_q       <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      lin_rld_q   <= lin_rld_d;
      mode_q      <= mode_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      load_pend_q <= load_pend_d;
      period_q    <= period_d;
      timer_q     <= timer_d;
      len_q       <= len_d;
      lin_q       <= lin_d;
      rflag_q     <= rflag_d;
      seq_q       <= seq_d;
    end
  end

  // Triangle folds the upper half upward: 15..0 then 0..15.
  assign tri_val         = seq_q[SEQ_W-1] ? seq_q[OUT_W-1:0] : ~seq_q[OUT_W-1:0];
  assign saw_val         = seq_q[SEQ_W-1:1];
  assign wave_out        = en_channel ? (mode_q ? saw_val : tri_val) : '0;
  assign lcounter_status = (len_q != 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_apu_wave_channel.sv
`default_nettype none
// ============================================================================
// Module   : tb_apu_wave_channel
// Purpose  : Scoreboard bench for apu_wave_channel against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apu_wave_channel;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu = 1'b0;
  logic       cs = 1'b0;
  logic [4:0] addr = 5'd0;
  logic [7:0] data = 8'd0;
  logic       wr = 1'b0;
  logic       en = 1'b0;
  logic       fl = 1'b0;
  logic       fe = 1'b0;
  logic       lstat;
  logic [3:0] wave;

  apu_wave_channel dut (
    .sysclk(clk), .reset(rst_n), .cpu_clock(cpu), .apu_cs(cs),
    .ioreg_addr(addr), .ioreg_datain(data), .ioreg_wr(wr),
    .en_channel(en), .frame_l(fl), .frame_e(fe),
    .lcounter_status(lstat), .wave_out(wave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] wave;
    logic       ls;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   phase  = 0;
  int   cur_tag = 0;

  int tbl[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                  12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

  // Reference state: plain integers describing the channel's observable rules.
  int m_r0, m_mode, m_r2, m_r3, m_lp, m_per, m_tmr, m_len, m_lin, m_flag, m_seq;

  task automatic model_clear();
    m_r0 = 0; m_mode = 0; m_r2 = 0; m_r3 = 0; m_lp = 0; m_per = 0;
    m_tmr = 0; m_len = 0; m_lin = 0; m_flag = 0; m_seq = 0;
  endtask

  function automatic int model_wave();
    if (!en) return 0;
    if (m_mode != 0) return m_seq / 2;
    return (m_seq >= 16) ? m_seq - 16 : 15 - m_seq;
  endfunction

  task automatic model_next();
    int ctrl, np, nt, nper, nl, nn, nf, ns, nlp;
    bit step, gate;
    if (!rst_n) begin
      model_clear();
      return;
    end
    ctrl = (m_r0 >> 7) & 1;
    np   = (m_r3 & 7) * 256 + m_r2;
    step = (cpu == 1'b1) && (m_lp == 0) && (m_tmr == 0);
    gate = (m_len != 0) && (m_lin != 0) && (m_per >= 2);
    if (m_lp != 0)      nt = np;
    else if (cpu)       nt = (m_tmr == 0) ? m_per : m_tmr - 1;
    else                nt = m_tmr;
    nper = (m_lp != 0) ? np : m_per;
    if (!en)                                       nl = 0;
    else if (m_lp != 0)                            nl = tbl[m_r3 >> 3];
    else if (fl && m_len != 0 && ctrl == 0)        nl = m_len - 1;
    else                                           nl = m_len;
    nf = (m_flag != 0 || m_lp != 0) ? 1 : 0;
    nn = m_lin;
    if (fe) begin
      nn = (nf != 0) ? (m_r0 & 127) : ((m_lin > 0) ? m_lin - 1 : 0);
      if (ctrl == 0) nf = 0;
    end
    ns  = (step && gate) ? (m_seq + 1) % 32 : m_seq;
    nlp = 0;
    if (cs && wr && cpu) begin
      case (addr)
        5'd8:  m_r0 = data;
        5'd9:  m_mode = data & 1;
        5'd10: m_r2 = data;
        5'd11: begin m_r3 = data; nlp = 1; end
        default: ;
      endcase
    end
    m_lp = nlp; m_tmr = nt; m_per = nper; m_len = nl; m_lin = nn;
    m_flag = nf; m_seq = ns;
  endtask

  // Inputs are already applied; record what the DUT must show this cycle.
  task automatic tick();
    exp_t e;
    if (!rst_n) model_clear();
    e.wave = 4'(model_wave());
    e.ls   = (m_len != 0);
    e.tag  = cur_tag;
    exp_q.push_back(e);
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    cs = 1'b0; wr = 1'b0; fl = 1'b0; fe = 1'b0;
    cpu = phase[0];
    phase++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle();
      tick();
    end
  endtask

  task automatic wreg(input logic [4:0] a, input logic [7:0] d);
    set_idle();
    cs = 1'b1; wr = 1'b1; cpu = 1'b1; addr = a; data = d;
    tick();
  endtask

  task automatic frame(input logic l, input logic e);
    set_idle();
    fl = l; fe = e;
    tick();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (wave !== e.wave || lstat !== e.ls)
        $display("FAIL t%0d @%0t: wave_out/lcounter_status got %0d/%0b expected %0d/%0b",
                 e.tag, $time, wave, lstat, e.wave, e.ls);
      else
        n_pass++;
    end
  end

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    cur_tag = 1;
    rst_n = 1'b0; idle(3);
    rst_n = 1'b1; idle(2);

    cur_tag = 2;
    en = 1'b1;
    wreg(5'd8, 8'h81); wreg(5'd9, 8'h00); wreg(5'd10, 8'h03); wreg(5'd11, 8'h08);
    idle(2); frame(1'b0, 1'b1);
    idle(300);

    cur_tag = 1;
    rst_n = 1'b0; idle(2);
    rst_n = 1'b1; idle(4);

    cur_tag = 3;
    wreg(5'd8, 8'h7F); wreg(5'd10, 8'h03); wreg(5'd11, 8'h00);
    idle(2); frame(1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      frame(1'b1, 1'b0);
      idle(9);
    end
    idle(40);

    cur_tag = 4;
    wreg(5'd8, 8'h03); wreg(5'd11, 8'h08);
    idle(2); frame(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(25);
      frame(1'b0, 1'b1);
    end
    idle(40);

    cur_tag = 5;
    wreg(5'd8, 8'h81); wreg(5'd9, 8'h01); wreg(5'd11, 8'h08);
    idle(1); frame(1'b0, 1'b1);
    idle(300);
    wreg(5'd10, 8'h01); wreg(5'd11, 8'h08);
    idle(60);
    wreg(5'd10, 8'h00); wreg(5'd11, 8'h08);
    idle(30);

    cur_tag = 6;
    wreg(5'd8, 8'h01); wreg(5'd10, 8'h02);
    wreg(5'd11, 8'h50);
    frame(1'b1, 1'b1);
    idle(20);
    wreg(5'd11, 8'h08); frame(1'b1, 1'b0);
    idle(10);
    en = 1'b0;
    wreg(5'd11, 8'h08); idle(10);
    en = 1'b1;
    idle(10);

    cur_tag = 7;
    for (int i = 0; i < 5000; i++) begin
      cs  = ($urandom_range(0, 99) < 15);
      wr  = $urandom_range(0, 1) == 1;
      cpu = $urandom_range(0, 1) == 1;
      addr = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'(8 + $urandom_range(0, 3));
      data = 8'($urandom);
      if (addr == 5'd10 && $urandom_range(0, 3) == 0) data = 8'($urandom_range(0, 3));
      if (addr == 5'd11 && $urandom_range(0, 1) == 0) data[2:0] = 3'd0;
      fl = ($urandom_range(0, 19) == 0);
      fe = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) en = ~en;
      rst_n = ($urandom_range(0, 1999) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle(4);

    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0)
      $display("FAIL drain: scoreboard entries left %0d expected 0", exp_q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
